param_universal_shift_register: RTL and testbench
=================================================

// Module: param_universal_shift_register
// PURPOSE
//   Parametrised, multi-mode shift/rotate register; successor to the fixed 128-bit cyclic left shifter.
//   Loads a word in parallel, then on command performs N single-bit steps, one per clock.
//   The step is a rotate, a logical shift or an arithmetic shift, in either direction.
//   Signals completion with busy/done, for sequencing by a controller FSM in the DCE datapath labs.
// PARAMETERS
//   WIDTH   128  register width in bits (>=2)
//   AMT_W   8    width of the step-count input; counts 0..2**AMT_W-1 legal
// PORTS
//   clock       in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high; clears all state
//   load        in   1        parallel load request (honoured in IDLE/DONE only)
//   d           in   WIDTH    parallel load data
//   start       in   1        start an N-step operation (honoured in IDLE/DONE only)
//   mode        in   3        000 ROL, 001 ROR, 010 SHL, 011 SHR logical, 100 SAR; others illegal
//   amount      in   AMT_W    number of single-bit steps N
//   serial_in   in   1        fill bit for SHL (enters LSB) and SHR (enters MSB)
//   q           out  WIDTH    register contents
//   serial_out  out  1        bit that left the boundary on the most recent step
//   busy        out  1        high while steps are executing (state RUN)
//   done        out  1        one-cycle completion pulse (state DONE)
// BEHAVIOUR
//   Reset (async, any time, incl. mid-operation):
//     q=0, serial_out=0, state=IDLE, busy=0, done=0, internal counter=0. All outputs are registered.
//   FSM states IDLE, RUN, DONE; busy=(RUN), done=(DONE).
//   IDLE/DONE, sampled at a rising edge:
//     - load=1: q<=d, go to IDLE. Load wins over start; start is dropped. serial_out unchanged.
//     - else start=1: latch mode and amount.
//         If N==0 or mode is illegal: go to DONE, q unchanged.
//         Otherwise: cnt<=N, go to RUN.
//     - else: DONE goes to IDLE; IDLE stays in IDLE.
//   RUN, each edge: one step using the latched mode, cnt<=cnt-1. When cnt==1, go to DONE.
//     load, start, mode, amount and serial_in-changes do not disturb the latched mode/count.
//     serial_in is sampled live on every step.
//   Steps (W=WIDTH); serial_out takes the bit that crossed the boundary:
//     ROL  q<={q[W-2:0],q[W-1]}               serial_out<=q[W-1]
//     ROR  q<={q[0],q[W-1:1]}                 serial_out<=q[0]
//     SHL  q<={q[W-2:0],serial_in}            serial_out<=q[W-1]
//     SHR  q<={serial_in,q[W-1:1]}            serial_out<=q[0]
//     SAR  q<={q[W-1],q[W-1:1]}               serial_out<=q[0]
//   Latency: the start-sampling edge is edge 0. Steps happen on edges 1..N.
//     done is high for exactly the cycle after edge N (after edge 0 when N==0 or mode is illegal).
//   Back-to-back: start or load sampled while done=1 is accepted; there is no idle gap.
//   N>=W is legal. A rotate by W restores q. Shifts saturate to fill (all serial_in / all sign bits).
// TESTING (bench runs WIDTH=8 and WIDTH=128)
//   W=8: reset mid-RUN -> q=0, busy=0, done=0 immediately, without waiting for a clock edge.
//   W=8: load d=8'h81; start ROL N=1 -> q=8'h03, serial_out=1, done one cycle after start.
//   W=8: load 8'hB4; start ROR N=3 -> busy for 3 cycles, then q=8'h96, done pulse of exactly 1 cycle.
//   W=8: load 8'h80; SAR N=5 -> q=8'hFC. Then SHR N=2, serial_in=0 -> q=8'h3F, serial_out=0.
//   W=128: load 128'h1; ROL N=128 -> q=128'h1 after 128 busy cycles. Then mode=3'b111 -> q unchanged, done next cycle.
//   W=8: load and start in the same cycle, and start during RUN -> start ignored, q=d, count undisturbed.

Source files
------------

// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift/rotate register: parallel load, then N single-bit
// rotate/shift steps (one per clock) with busy/done handshake for a controller FSM.
module param_universal_shift_register #(
    parameter int WIDTH = 128,
    parameter int AMT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] MODE_ROL = 3'd0;
    localparam logic [2:0] MODE_ROR = 3'd1;
    localparam logic [2:0] MODE_SHL = 3'd2;
    localparam logic [2:0] MODE_SHR = 3'd3;
    localparam logic [2:0] MODE_SAR = 3'd4;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             so_q, so_d;
    logic [2:0]       mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] stepVal;
    logic             stepBit;
    logic             startGo;

    // A start only enters RUN when there is real work: legal mode and nonzero count.
    assign startGo = (mode <= MODE_SAR) && (amount != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            so_q    <= 1'b0;
            mode_q  <= MODE_ROL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            so_q    <= so_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load)
                    state_d = IDLE;
                else if (start)
                    state_d = startGo ? RUN : DONE;
                else
                    state_d = IDLE;
            end
            RUN:     state_d = (cnt_q == AMT_W'(1)) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stepVal = shift_q;
        stepBit = so_q;
        case (mode_q)
            MODE_ROL: begin
                stepVal = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
                stepBit = shift_q[WIDTH-1];
            end
            MODE_ROR: begin
                stepVal = {shift_q[0], shift_q[WIDTH-1:1]};
                stepBit = shift_q[0];
            end
            MODE_SHL: begin
                stepVal = {shift_q[WIDTH-2:0], serial_in};
                stepBit = shift_q[WIDTH-1];
            end
            MODE_SHR: begin
                stepVal = {serial_in, shift_q[WIDTH-1:1]};
                stepBit = shift_q[0];
            end
            MODE_SAR: begin
                stepVal = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
                stepBit = shift_q[0];
            end
            default: begin
                stepVal = shift_q;
                stepBit = so_q;
            end
        endcase
    end

    // While RUN, the latched mode/count are frozen regardless of load/start activity.
    always_comb begin
        shift_d = shift_q;
        so_d    = so_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    shift_d = d;
                end else if (start) begin
                    mode_d = mode;
                    cnt_d  = startGo ? amount : '0;
                end
            end
            RUN: begin
                shift_d = stepVal;
                so_d    = stepBit;
                cnt_d   = cnt_q - AMT_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign q          = shift_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Self-checking bench for param_universal_shift_register at WIDTH=8 and WIDTH=128,
// with directed cases plus randomized operations against an arithmetic reference model.
module tb_param_universal_shift_register;

    logic         clock;
    logic         reset;

    logic         load8, start8, si8;
    logic [7:0]   d8;
    logic [2:0]   mode8;
    logic [7:0]   amount8;
    logic [7:0]   q8;
    logic         so8, busy8, done8;

    logic         load128, start128, si128;
    logic [127:0] d128;
    logic [2:0]   mode128;
    logic [7:0]   amount128;
    logic [127:0] q128;
    logic         so128, busy128, done128;

    int           errors;
    int           checks;
    logic [7:0]   mq;
    logic         mso;

    param_universal_shift_register #(.WIDTH(8), .AMT_W(8)) dut8 (
        .clock(clock), .reset(reset), .load(load8), .d(d8), .start(start8),
        .mode(mode8), .amount(amount8), .serial_in(si8), .q(q8),
        .serial_out(so8), .busy(busy8), .done(done8)
    );

    param_universal_shift_register #(.WIDTH(128), .AMT_W(8)) dut128 (
        .clock(clock), .reset(reset), .load(load128), .d(d128), .start(start128),
        .mode(mode128), .amount(amount128), .serial_in(si128), .q(q128),
        .serial_out(so128), .busy(busy128), .done(done128)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Final register value after n steps, computed directly rather than step by step.
    function automatic logic [7:0] modelQ(input logic [7:0] qIn, input logic [2:0] m,
                                          input int n, input bit si);
        int v;
        int k;
        v = int'(qIn);
        case (m)
            3'd0: begin k = n % 8; return 8'((v << k) | (v >> (8 - k))); end
            3'd1: begin k = n % 8; return 8'((v >> k) | (v << (8 - k))); end
            3'd2: begin
                if (n >= 8) return si ? 8'hFF : 8'h00;
                return 8'((v << n) | (si ? ((1 << n) - 1) : 0));
            end
            3'd3: begin
                if (n >= 8) return si ? 8'hFF : 8'h00;
                return 8'((v >> n) | (si ? (255 << (8 - n)) : 0));
            end
            3'd4: begin
                if (n >= 8) return qIn[7] ? 8'hFF : 8'h00;
                if (qIn[7]) v = v - 256;
                return 8'(v >>> n);
            end
            default: return qIn;
        endcase
    endfunction

    function automatic logic modelSo(input logic [7:0] qIn, input logic [2:0] m,
                                     input int n, input bit si);
        logic [7:0] t;
        case (m)
            3'd0: begin t = modelQ(qIn, m, n, si);     return t[0]; end
            3'd1: begin t = modelQ(qIn, m, n, si);     return t[7]; end
            3'd2: begin t = modelQ(qIn, m, n - 1, si); return t[7]; end
            default: begin t = modelQ(qIn, m, n - 1, si); return t[0]; end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadWord8(input logic [7:0] val);
        load8 = 1'b1;
        d8    = val;
        @(negedge clock);
        load8 = 1'b0;
        checkOutput("load8.q", 128'(q8), 128'(val));
        checkOutput("load8.so", 128'(so8), 128'(mso));
        mq = val;
    endtask

    // Issues one operation on the 8-bit DUT; optionally disturbs inputs mid-RUN.
    task automatic applyStimulus(input logic [2:0] m, input int n, input bit si,
                                 input bit disturb, input bit idleAfter);
        logic [7:0] expQ;
        logic       expSo;
        int         cycles;
        bit         quick;
        quick = (n == 0) || (m > 3'd4);
        expQ  = quick ? mq : modelQ(mq, m, n, si);
        expSo = quick ? mso : modelSo(mq, m, n, si);
        start8  = 1'b1;
        mode8   = m;
        amount8 = 8'(n);
        si8     = si;
        @(negedge clock);
        start8 = 1'b0;
        cycles = 0;
        while (busy8 && cycles < 300) begin
            if (disturb && cycles == 0) begin
                load8   = 1'b1;
                d8      = ~mq;
                start8  = 1'b1;
                mode8   = m + 3'd1;
                amount8 = amount8 + 8'd3;
            end
            @(negedge clock);
            cycles++;
        end
        load8  = 1'b0;
        start8 = 1'b0;
        checkOutput("busyCycles", 128'(cycles), quick ? 128'd0 : 128'(n));
        checkOutput("donePulse", 128'(done8), 128'd1);
        checkOutput("resultQ", 128'(q8), 128'(expQ));
        checkOutput("serialOut", 128'(so8), 128'(expSo));
        mq  = expQ;
        mso = expSo;
        if (idleAfter) begin
            @(negedge clock);
            checkOutput("doneCleared", 128'(done8), 128'd0);
            checkOutput("idleNotBusy", 128'(busy8), 128'd0);
        end
    endtask

    initial begin
        int cycles;
        errors = 0; checks = 0; mq = 8'h00; mso = 1'b0;
        reset = 1'b1;
        load8 = 0; start8 = 0; si8 = 0; d8 = '0; mode8 = '0; amount8 = '0;
        load128 = 0; start128 = 0; si128 = 0; d128 = '0; mode128 = '0; amount128 = '0;

        @(negedge clock);
        checkOutput("reset.q8", 128'(q8), 128'd0);
        checkOutput("reset.busy8", 128'(busy8), 128'd0);
        checkOutput("reset.done8", 128'(done8), 128'd0);
        checkOutput("reset.q128", q128, 128'd0);
        reset = 1'b0;
        @(negedge clock);

        loadWord8(8'h81);
        applyStimulus(3'd0, 1, 1'b0, 1'b0, 1'b1);
        checkOutput("rol1.q", 128'(q8), 128'h03);

        loadWord8(8'hB4);
        applyStimulus(3'd1, 3, 1'b0, 1'b0, 1'b1);
        checkOutput("ror3.q", 128'(q8), 128'h96);

        loadWord8(8'h80);
        applyStimulus(3'd4, 5, 1'b0, 1'b0, 1'b0);
        checkOutput("sar5.q", 128'(q8), 128'hFC);
        applyStimulus(3'd3, 2, 1'b0, 1'b0, 1'b1);
        checkOutput("shr2.q", 128'(q8), 128'h3F);

        load8 = 1'b1; d8 = 8'h5A; start8 = 1'b1; mode8 = 3'd0; amount8 = 8'd3;
        @(negedge clock);
        load8 = 1'b0; start8 = 1'b0;
        checkOutput("loadWins.q", 128'(q8), 128'h5A);
        checkOutput("loadWins.busy", 128'(busy8), 128'd0);
        checkOutput("loadWins.done", 128'(done8), 128'd0);
        mq = 8'h5A;

        applyStimulus(3'd2, 4, 1'b1, 1'b1, 1'b1);
        checkOutput("shl4disturbed.q", 128'(q8), 128'hAF);

        start8 = 1'b1; mode8 = 3'd0; amount8 = 8'd10;
        @(negedge clock);
        start8 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncReset.q", 128'(q8), 128'd0);
        checkOutput("asyncReset.so", 128'(so8), 128'd0);
        checkOutput("asyncReset.busy", 128'(busy8), 128'd0);
        checkOutput("asyncReset.done", 128'(done8), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        mq = 8'h00; mso = 1'b0;
        @(negedge clock);

        load128 = 1'b1; d128 = 128'h1;
        @(negedge clock);
        load128 = 1'b0;
        start128 = 1'b1; mode128 = 3'd0; amount128 = 8'd128;
        @(negedge clock);
        start128 = 1'b0;
        cycles = 0;
        while (busy128 && cycles < 300) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("w128.busyCycles", 128'(cycles), 128'd128);
        checkOutput("w128.done", 128'(done128), 128'd1);
        checkOutput("w128.q", q128, 128'h1);
        checkOutput("w128.so", 128'(so128), 128'd1);
        start128 = 1'b1; mode128 = 3'b111; amount128 = 8'd5;
        @(negedge clock);
        start128 = 1'b0;
        checkOutput("w128.illegal.done", 128'(done128), 128'd1);
        checkOutput("w128.illegal.busy", 128'(busy128), 128'd0);
        checkOutput("w128.illegal.q", q128, 128'h1);
        @(negedge clock);
        checkOutput("w128.illegal.doneClr", 128'(done128), 128'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) loadWord8(8'($urandom));
            applyStimulus(3'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
